// File: rtl/gate_truth_table_checker_pkg.sv
// gate_truth_table_checker_pkg: shared FSM state encoding and reference two-input truth tables
package gate_truth_table_checker_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
endpackage

// File: rtl/gate_truth_table_checker_sync.sv
// gate_chk_sync: two-flop synchronizer for a gate output arriving from external pins
module gate_chk_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the raw input through two flops; both clear on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps all input vectors of a gate under test and scores its output against a truth table (GATE_CHK_SYNC_EN adds an input synchronizer)
module gate_truth_table_checker
  import gate_truth_table_checker_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [2**NUM_IN-1:0] EXP_TABLE = TT_AND
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [NUM_IN-1:0]     gate_in,
  input  logic                  gate_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2**NUM_IN-1:0]  fail_vec,
  output logic [NUM_IN:0]       err_count
);
`ifdef GATE_CHK_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam int CW = $clog2(SETTLE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_LEN - 1);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic samp;
  logic last_vec;
  logic miss;
`ifdef GATE_CHK_SYNC_EN
  gate_chk_sync u_sync (.clk(clk), .rst_n(rst_n), .d(gate_out), .q(samp));
`else
  assign samp = gate_out;
`endif
  assign last_vec = &gate_in;
  assign miss = samp != EXP_TABLE[gate_in];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= next;
  // next-state and status decode; start outside IDLE is simply not looked at
  always_comb begin
    next = state;
    busy = 1'b0;
    done = 1'b0;
    next = state == ST_IDLE   ? (start ? ST_SETTLE : ST_IDLE) :
           state == ST_SETTLE ? (cnt == CNT_LAST ? ST_SAMPLE : ST_SETTLE) :
           state == ST_SAMPLE ? (last_vec ? ST_DONE : ST_SETTLE) : ST_IDLE;
    busy = state == ST_SETTLE || state == ST_SAMPLE;
    done = state == ST_DONE;
  end
  // vector stepping, settle timing and mismatch scoreboard
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gate_in   <= '0;
      fail_vec  <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          gate_in   <= '0;
          fail_vec  <= '0;
          err_count <= '0;
          pass      <= 1'b0;
          cnt       <= '0;
        end
        ST_SETTLE: cnt <= cnt == CNT_LAST ? '0 : cnt + 1'b1;
        ST_SAMPLE: begin
          if (miss) begin
            fail_vec[gate_in] <= 1'b1;
            err_count         <= err_count + 1'b1;
          end
          if (!last_vec) gate_in <= gate_in + 1'b1;
        end
        ST_DONE: begin
          pass    <= err_count == '0;
          gate_in <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: scoreboard bench driving AND/OR/stuck/NAND gate models into AND- and NAND-table checkers
module tb_gate_truth_table_checker;
  import gate_truth_table_checker_pkg::*;
  localparam int SC = 2;
`ifdef GATE_CHK_SYNC_EN
  localparam int VEC_CYC = SC + 3;
`else
  localparam int VEC_CYC = SC + 1;
`endif
  localparam int BUSY_CYC = 4 * VEC_CYC;
  typedef struct packed {
    logic       p;
    logic [3:0] fv;
    logic [2:0] ec;
  } res_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] gi_a, gi_n;
  logic go_a, go_n, busy_a, busy_n, done_a, done_n, pass_a, pass_n;
  logic [3:0] fv_a, fv_n;
  logic [2:0] ec_a, ec_n;
  int mode = 0;
  int n_cmp = 0, n_bad = 0;
  res_t q_a[$], q_n[$];
  always #5 clk = ~clk;
  function automatic logic gut(input int m, input logic [1:0] v);
    case (m)
      0: return v[1] & v[0];
      1: return v[1] | v[0];
      2: return 1'b0;
      default: return !(v[1] & v[0]);
    endcase
  endfunction
  function automatic res_t model(input int m, input logic [3:0] tt);
    res_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r.fv[i] = tt[i] != gut(m, 2'(i));
      r.ec = r.ec + 3'(r.fv[i]);
    end
    r.p = r.ec == 0;
    return r;
  endfunction
  assign go_a = gut(mode, gi_a);
  assign go_n = gut(mode, gi_n);
  gate_truth_table_checker #(.NUM_IN(2), .SETTLE_CYCLES(SC), .EXP_TABLE(TT_AND)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gi_a), .gate_out(go_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_vec(fv_a), .err_count(ec_a));
  gate_truth_table_checker #(.NUM_IN(2), .SETTLE_CYCLES(SC), .EXP_TABLE(TT_NAND)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gi_n), .gate_out(go_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_vec(fv_n), .err_count(ec_n));
  task automatic test_reset();
    rst_n = 0;
    #23;
    n_cmp++;
    if ({busy_a, done_a, pass_a, fv_a, ec_a, gi_a} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_a: got %h want 000", {busy_a, done_a, pass_a, fv_a, ec_a, gi_a});
    end
    n_cmp++;
    if ({busy_n, done_n, pass_n, fv_n, ec_n, gi_n} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_n: got %h want 000", {busy_n, done_n, pass_n, fv_n, ec_n, gi_n});
    end
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_sweep(input string nm, input int m, input int restart_at, input bit restart_done);
    int nbusy, ndone, done_at;
    res_t e, g;
    mode = m;
    q_a.push_back(model(m, TT_AND));
    q_n.push_back(model(m, TT_NAND));
    nbusy = 0;
    ndone = 0;
    done_at = -1;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 0; c < BUSY_CYC + 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1 start = 0;
      end
      if (busy_a) nbusy++;
      if (done_a) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 0) begin
        n_cmp++;
        if ({pass_a, fv_a, ec_a, pass_n, fv_n, ec_n} !== 16'h0) begin
          n_bad++;
          $display("FAIL %s_clear: got %h want 0000", nm, {pass_a, fv_a, ec_a, pass_n, fv_n, ec_n});
        end
      end
      if (c < BUSY_CYC && c % VEC_CYC == 0) begin
        n_cmp++;
        if (gi_a !== 2'(c / VEC_CYC)) begin
          n_bad++;
          $display("FAIL %s_gate_in@%0d: got %0d want %0d", nm, c, gi_a, c / VEC_CYC);
        end
      end
      if (c == restart_at || (restart_done && done_a)) start = 1;
    end
    n_cmp++;
    if (nbusy != BUSY_CYC) begin
      n_bad++;
      $display("FAIL %s_busy_len: got %0d want %0d", nm, nbusy, BUSY_CYC);
    end
    n_cmp++;
    if (done_at != BUSY_CYC || ndone != 1) begin
      n_bad++;
      $display("FAIL %s_done: got cycle %0d count %0d want cycle %0d count 1", nm, done_at, ndone, BUSY_CYC);
    end
    e = q_a.pop_front();
    g = '{p: pass_a, fv: fv_a, ec: ec_a};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s_and_result: got pass=%b fv=%b ec=%0d want pass=%b fv=%b ec=%0d", nm, g.p, g.fv, g.ec, e.p, e.fv, e.ec);
    end
    e = q_n.pop_front();
    g = '{p: pass_n, fv: fv_n, ec: ec_n};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s_nand_result: got pass=%b fv=%b ec=%0d want pass=%b fv=%b ec=%0d", nm, g.p, g.fv, g.ec, e.p, e.fv, e.ec);
    end
  endtask
  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    mode = 1;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (done_a) ndone++;
    end
    n_cmp++;
    if (fv_a !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_partial: got fv=%b want 0010", fv_a);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({busy_a, done_a, pass_a, fv_a, ec_a, gi_a} !== 12'h0) begin
      n_bad++;
      $display("FAIL mid_async_clear: got %h want 000", {busy_a, done_a, pass_a, fv_a, ec_a, gi_a});
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done_a) ndone++;
    end
    @(negedge clk) rst_n = 1;
    repeat (BUSY_CYC) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL mid_no_done: got %0d done/busy cycles want 0", ndone);
    end
  endtask
  initial begin
    test_reset();
    test_sweep("and_ok", 0, -1, 0);
    test_sweep("or_wrong", 1, -1, 0);
    test_sweep("stuck0", 2, -1, 0);
    test_sweep("nand", 3, -1, 0);
    test_sweep("restart", 1, 5, 1);
    test_reset_mid();
    test_sweep("after_rst", 0, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
